// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings plus the command master's response codes and FSM states.
// Also imported by the register-bank slave, so it keeps the HTRANS values the master never drives.
package ahb_lite_pkg;

   localparam int unsigned HADDR_WIDTH = 32;
   localparam int unsigned HDATA_WIDTH = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [2:0] HSIZE_WORD      = 3'b010;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   typedef enum logic [1:0] {
      RSP_OK         = 2'b00,
      RSP_BUS_ERR    = 2'b01,
      RSP_TIMEOUT    = 2'b10,
      RSP_DECODE_ERR = 2'b11
   } rsp_code_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP,
      ST_DRAIN
   } mst_state_e;

endpackage

// File: rtl/ahb_wait_timer.sv
// Saturating data-phase wait-state counter; expired_o flags the wait cycle that reaches LIMIT.
module ahb_wait_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CW'(LIMIT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Asserted during the wait cycle whose increment brings the count to LIMIT.
   assign expired_o = en_i && (cnt_q >= CW'(LIMIT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ahb_cmd_master.sv
// Valid/ready command port to single non-overlapped AHB-lite word transfers, with
// address-window decode, bus-error and data-phase timeout reporting.
module ahb_cmd_master
   import ahb_lite_pkg::*;
#(
   parameter logic [HADDR_WIDTH-1:0] HADDR_BASE     = 32'h8000_0000,
   parameter logic [HADDR_WIDTH-1:0] HADDR_MASK     = 32'hFFFF_F000,
   parameter int unsigned            TIMEOUT_CYCLES = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic                   cmd_write_i,
   input  logic [HADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [HDATA_WIDTH-1:0] cmd_wdata_i,
   output logic                   rsp_valid_o,
   output logic [HDATA_WIDTH-1:0] rsp_rdata_o,
   output logic [1:0]             rsp_code_o,
   output logic                   hsel_o,
   output logic [HADDR_WIDTH-1:0] haddr_o,
   output logic                   hwrite_o,
   output logic [1:0]             htrans_o,
   output logic [2:0]             hsize_o,
   output logic [2:0]             hburst_o,
   output logic [3:0]             hprot_o,
   output logic                   hmastlock_o,
   output logic [HDATA_WIDTH-1:0] hwdata_o,
   input  logic                   hready_i,
   input  logic                   hresp_i,
   input  logic [HDATA_WIDTH-1:0] hrdata_i
);

   mst_state_e             state_q, state_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [HDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   rsp_code_e              rsp_code_q, rsp_code_d;
   logic                   hsel_q, hsel_d;
   logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic                   hwrite_q, hwrite_d;
   logic [1:0]             htrans_q, htrans_d;
   logic [HDATA_WIDTH-1:0] hwdata_q, hwdata_d;
   logic [HDATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                   tmr_clr, tmr_en, tmr_expired;
   logic                   decode_err;

   ahb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   assign decode_err = (cmd_addr_i[1:0] != 2'b00) ||
                       ((cmd_addr_i & HADDR_MASK) != HADDR_BASE);

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_code_d  = rsp_code_q;
      hsel_d      = hsel_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      htrans_d    = htrans_q;
      hwdata_d    = hwdata_q;
      wdata_d     = wdata_q;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               if (decode_err) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_code_d  = RSP_DECODE_ERR;
                  rsp_rdata_d = '0;
               end else begin
                  state_d  = ST_ADDR;
                  haddr_d  = cmd_addr_i;
                  hwrite_d = cmd_write_i;
                  wdata_d  = cmd_wdata_i;
                  htrans_d = HTRANS_NONSEQ;
                  hsel_d   = 1'b1;
                  tmr_clr  = 1'b1;
               end
            end
         end

         ST_ADDR: begin
            if (hready_i) begin
               state_d  = ST_DATA;
               htrans_d = HTRANS_IDLE;
               hsel_d   = 1'b0;
               hwdata_d = wdata_q;
            end
         end

         ST_DATA: begin
            // The first ERROR cycle (hresp high, hready low) is just another wait cycle here.
            if (hready_i) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               if (hresp_i) begin
                  rsp_code_d  = RSP_BUS_ERR;
                  rsp_rdata_d = '0;
               end else begin
                  rsp_code_d  = RSP_OK;
                  rsp_rdata_d = hwrite_q ? '0 : hrdata_i;
               end
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) begin
                  state_d     = ST_DRAIN;
                  rsp_valid_d = 1'b1;
                  rsp_code_d  = RSP_TIMEOUT;
                  rsp_rdata_d = '0;
               end
            end
         end

         ST_RESP: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
         end

         ST_DRAIN: begin
            // The abandoned data phase still owns the bus until the slave releases HREADY.
            if (hready_i) begin
               state_d     = ST_IDLE;
               cmd_ready_d = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_code_q  <= RSP_OK;
         hsel_q      <= 1'b0;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         htrans_q    <= HTRANS_IDLE;
         hwdata_q    <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_code_q  <= rsp_code_d;
         hsel_q      <= hsel_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         htrans_q    <= htrans_d;
         hwdata_q    <= hwdata_d;
         wdata_q     <= wdata_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_code_o  = rsp_code_q;
   assign hsel_o      = hsel_q;
   assign haddr_o     = haddr_q;
   assign hwrite_o    = hwrite_q;
   assign htrans_o    = htrans_q;
   assign hwdata_o    = hwdata_q;
   assign hsize_o     = HSIZE_WORD;
   assign hburst_o    = HBURST_SINGLE;
   assign hprot_o     = HPROT_DATA_PRIV;
   assign hmastlock_o = 1'b0;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Scoreboard bench for ahb_cmd_master: a behavioural register-bank slave with scripted
// wait/error behaviour, a reference model that predicts each response, and a response monitor.
module tb_ahb_cmd_master;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_write_i = 1'b0;
   logic [31:0] cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_code_o;
   logic        hsel_o;
   logic [31:0] haddr_o;
   logic        hwrite_o;
   logic [1:0]  htrans_o;
   logic [2:0]  hsize_o;
   logic [2:0]  hburst_o;
   logic [3:0]  hprot_o;
   logic        hmastlock_o;
   logic [31:0] hwdata_o;
   logic        hready_i = 1'b1;
   logic        hresp_i = 1'b0;
   logic [31:0] hrdata_i = '0;

   ahb_cmd_master #(
      .HADDR_BASE     (32'h8000_0000),
      .HADDR_MASK     (32'hFFFF_F000),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_code_o  (rsp_code_o),
      .hsel_o      (hsel_o),
      .haddr_o     (haddr_o),
      .hwrite_o    (hwrite_o),
      .htrans_o    (htrans_o),
      .hsize_o     (hsize_o),
      .hburst_o    (hburst_o),
      .hprot_o     (hprot_o),
      .hmastlock_o (hmastlock_o),
      .hwdata_o    (hwdata_o),
      .hready_i    (hready_i),
      .hresp_i     (hresp_i),
      .hrdata_i    (hrdata_i)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          waits;
      bit          err;
   } bus_t;

   typedef struct {
      logic [1:0]  code;
      logic [31:0] rdata;
      int unsigned cyc;
      bit          drain;
   } exp_t;

   bus_t        bus_q[$];
   exp_t        exp_q[$];
   logic [31:0] model_mem [0:1023];
   logic [31:0] slave_mem [0:1023];
   int          n_chk = 0;
   int          n_pass = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   task automatic check_reset_vals();
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("rst_rsp_code",  32'(rsp_code_o), 32'd0);
      chk("rst_htrans",    32'(htrans_o), 32'd0);
      chk("rst_hsel",      32'(hsel_o), 32'd0);
      chk("rst_haddr",     haddr_o, 32'd0);
      chk("rst_hwrite",    32'(hwrite_o), 32'd0);
      chk("rst_hwdata",    hwdata_o, 32'd0);
   endtask

   // Behavioural register-bank slave; each bus transfer follows the script pushed at issue time.
   initial begin
      bus_t cur;
      bit   dp_active;
      bit   dp_next;
      bit   in_dp;
      bit   r;
      int   dcnt;
      dp_active = 0;
      dp_next   = 0;
      dcnt      = 0;
      cur       = '{32'd0, 1'b0, 32'd0, 0, 1'b0};
      forever begin
         @(posedge clk);
         r = rst_i;
         #1;
         if (r) begin
            dp_active = 0;
            dp_next   = 0;
            bus_q.delete();
            hready_i  = 1'b1;
            hresp_i   = 1'b0;
            continue;
         end
         if (dp_next) begin
            dp_active = 1;
            dp_next   = 0;
            dcnt      = 0;
         end
         in_dp    = dp_active;
         hrdata_i = $urandom;
         if (dp_active) begin
            chk("dp_haddr_stable", haddr_o, cur.addr);
            chk("dp_hwdata_stable", hwdata_o, cur.wdata);
            chk("dp_bus_idle", 32'({hsel_o, htrans_o}), 32'd0);
            if (dcnt < cur.waits) begin
               hready_i = 1'b0;
               hresp_i  = 1'b0;
            end else if (cur.err && dcnt == cur.waits) begin
               hready_i = 1'b0;
               hresp_i  = 1'b1;
            end else begin
               hready_i = 1'b1;
               hresp_i  = cur.err;
               if (!cur.err) begin
                  if (cur.wr) slave_mem[cur.addr[11:2]] = hwdata_o;
                  else        hrdata_i = slave_mem[cur.addr[11:2]];
               end
               dp_active = 0;
            end
            dcnt++;
         end else begin
            hready_i = 1'b1;
            hresp_i  = 1'b0;
         end
         if (htrans_o != 2'b00) begin
            chk("no_overlap", 32'(in_dp), 32'd0);
            chk("htrans_nonseq", 32'(htrans_o), 32'h2);
            if (hready_i) begin
               if (bus_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_nonseq: got htrans=%b haddr=%h required no transfer", htrans_o, haddr_o);
               end else begin
                  cur = bus_q.pop_front();
                  chk("addr_haddr", haddr_o, cur.addr);
                  chk("addr_hwrite", 32'(hwrite_o), 32'(cur.wr));
                  chk("addr_hsel", 32'(hsel_o), 32'd1);
                  chk("addr_ctrl", 32'({hsize_o, hburst_o, hprot_o, hmastlock_o}), 32'({3'b010, 3'b000, 4'b0011, 1'b0}));
                  dp_next = 1;
               end
            end
         end
      end
   end

   // Response monitor.
   initial begin
      exp_t e;
      bit   ready_due;
      ready_due = 0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            ready_due = 0;
            continue;
         end
         if (ready_due) chk("ready_after_rsp", 32'(cmd_ready_o), 32'd1);
         ready_due = 0;
         if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 code=%b required rsp_valid=0 (cycle %0d)", rsp_code_o, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_code", 32'(rsp_code_o), 32'(e.code));
               chk("rsp_rdata", rsp_rdata_o, e.rdata);
               chk("rsp_cycle", cyc, e.cyc);
               chk("rsp_busy", 32'(cmd_ready_o), 32'd0);
               ready_due = !e.drain;
            end
         end
      end
   end

   task automatic finish_summary();
      $display("%0d/%0d checks passed", n_pass, n_chk);
   endtask

   // Issues one command; the reference model predicts code, data and response cycle from the rules.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input bit err, input bit expect_rsp);
      bit   ok;
      int   lowc;
      int   n;
      exp_t e;
      bus_t b;
      ok = (addr[1:0] == 2'b00) && ((addr & 32'hFFFF_F000) == 32'h8000_0000);
      if (ok) begin
         b = '{addr, wr, wd, waits, err};
         bus_q.push_back(b);
      end
      cmd_valid_i = 1'b1;
      cmd_write_i = wr;
      cmd_addr_i  = addr;
      cmd_wdata_i = wd;
      n = 0;
      while (!cmd_ready_o) begin
         if (n == 300) begin
            n_chk++;
            $display("FAIL cmd_ready_timeout: got cmd_ready=0 for 300 cycles required 1");
            finish_summary();
            $fatal(1, "command port stuck");
         end
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'($urandom);
      cmd_addr_i  = $urandom;
      cmd_wdata_i = $urandom;
      if (!expect_rsp) return;
      if (!ok) begin
         e = '{2'b11, 32'd0, cyc, 1'b0};
      end else begin
         lowc = waits + (err ? 1 : 0);
         if (lowc >= TO) begin
            e = '{2'b10, 32'd0, cyc + 1 + TO, 1'b1};
         end else if (err) begin
            e = '{2'b01, 32'd0, cyc + 3 + waits, 1'b0};
         end else begin
            if (wr) model_mem[addr[11:2]] = wd;
            e = '{2'b00, wr ? 32'd0 : model_mem[addr[11:2]], cyc + 2 + waits, 1'b0};
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("pending_rsp", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      n_chk++;
      $display("FAIL watchdog: got simulation still running required completion");
      finish_summary();
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          r;
      for (int i = 0; i < 1024; i++) begin
         model_mem[i] = 32'd0;
         slave_mem[i] = 32'd0;
      end
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      rst_i = 1'b0;
      @(posedge clk);
      #1;

      issue(1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 0, 1'b0, 1'b1);
      issue(1'b0, 32'h8000_0008, 32'h0, 0, 1'b0, 1'b1);
      issue(1'b0, 32'h8000_0006, 32'h0, 0, 1'b0, 1'b1);
      issue(1'b0, 32'h9000_0000, 32'h0, 0, 1'b0, 1'b1);
      issue(1'b0, 32'h8000_0008, 32'h0, 3, 1'b0, 1'b1);
      issue(1'b1, 32'h8000_000C, 32'h1234_5678, 2, 1'b0, 1'b1);
      issue(1'b0, 32'h8000_000C, 32'h0, 0, 1'b1, 1'b1);
      issue(1'b0, 32'h8000_000C, 32'h0, 1, 1'b0, 1'b1);
      issue(1'b0, 32'h8000_0010, 32'h0, 20, 1'b0, 1'b1);
      issue(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 0, 1'b0, 1'b1);
      issue(1'b0, 32'h8000_0010, 32'h0, 0, 1'b0, 1'b1);
      wait_idle();

      // Reset pulsed while the read sits in its data phase; that command must vanish silently.
      issue(1'b0, 32'h8000_0008, 32'h0, 5, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals();
      rst_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 8)       a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
         else if (r == 8) a = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
         else             a = $urandom & 32'h7FFF_FFFC;
         issue(1'($urandom), a, $urandom, $urandom_range(0, 4), ($urandom_range(0, 9) == 0), 1'b1);
      end
      wait_idle();

      finish_summary();
      $finish;
   end

endmodule
